// File: rtl/lemming_pkg.sv
// Shared types and helpers for the lemming swarm controller.
// Holds the per-channel state encoding and a constant max helper.
package lemming_pkg;

   typedef enum logic [3:0] {
      WALK_L,
      WALK_R,
      FALL_L,
      FALL_R,
      DIG_L,
      DIG_R,
      JUMP_L,
      JUMP_R,
      SPLAT
   } lem_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/lemming_core.sv
// One lemming channel: state register, shared fall/dig/jump counter
// and Moore output decode.
module lemming_core
   import lemming_pkg::*;
#(
   parameter int FALL_LIMIT  = 20,
   parameter int JUMP_CYCLES = 3,
   parameter int DIG_LIMIT   = 0
) (
   input  logic clk,
   input  logic areset,
   input  logic ground,
   input  logic bump_left,
   input  logic bump_right,
   input  logic small_bump_left,
   input  logic small_bump_right,
   input  logic dig,
   input  logic revive,
   output logic walk_left,
   output logic walk_right,
   output logic aah,
   output logic digging,
   output logic jumping,
   output logic splat
);

   localparam int CW = $clog2(max3(FALL_LIMIT, JUMP_CYCLES, DIG_LIMIT) + 1);
   localparam logic [CW-1:0] FALL_MAX  = CW'(FALL_LIMIT);
   localparam logic [CW-1:0] FALL_LAST = CW'(FALL_LIMIT - 1);
   localparam logic [CW-1:0] JUMP_LAST = CW'(JUMP_CYCLES - 1);
   localparam logic [CW-1:0] DIG_LAST  = CW'((DIG_LIMIT > 0) ? DIG_LIMIT - 1 : 0);

   lem_state_t      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            go_left;
   logic            wall;
   logic            ledge;
   lem_state_t      walk_st, back_st, fall_st, dig_st, jump_st;

   assign go_left = (state_q == WALK_L) || (state_q == FALL_L) ||
                    (state_q == DIG_L)  || (state_q == JUMP_L);
   assign wall    = go_left ? bump_left : bump_right;
   assign ledge   = go_left ? small_bump_left : small_bump_right;
   assign walk_st = go_left ? WALK_L : WALK_R;
   assign back_st = go_left ? WALK_R : WALK_L;
   assign fall_st = go_left ? FALL_L : FALL_R;
   assign dig_st  = go_left ? DIG_L  : DIG_R;
   assign jump_st = go_left ? JUMP_L : JUMP_R;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q <= WALK_L;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         WALK_L, WALK_R: begin
            cnt_d = '0;
            if (!ground)    state_d = fall_st;
            else if (dig)   state_d = dig_st;
            else if (wall)  state_d = back_st;
            else if (ledge) state_d = jump_st;
         end
         FALL_L, FALL_R: begin
            cnt_d = (cnt_q == FALL_MAX) ? cnt_q : cnt_q + CW'(1);
            // Landing includes the current fall cycle in the count.
            if (ground) begin
               state_d = (cnt_q >= FALL_LAST) ? SPLAT : walk_st;
               cnt_d   = '0;
            end
         end
         DIG_L, DIG_R: begin
            cnt_d = (DIG_LIMIT > 0) ? cnt_q + CW'(1) : cnt_q;
            if (!ground) begin
               state_d = fall_st;
               cnt_d   = '0;
            end else if ((DIG_LIMIT > 0) && (cnt_q == DIG_LAST)) begin
               state_d = walk_st;
               cnt_d   = '0;
            end
         end
         JUMP_L, JUMP_R: begin
            cnt_d = cnt_q + CW'(1);
            if (!ground) begin
               state_d = fall_st;
               cnt_d   = '0;
            end else if (cnt_q == JUMP_LAST) begin
               state_d = walk_st;
               cnt_d   = '0;
            end
         end
         SPLAT: begin
            if (revive) begin
               state_d = WALK_L;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = WALK_L;
            cnt_d   = '0;
         end
      endcase
   end

   assign walk_left  = (state_q == WALK_L);
   assign walk_right = (state_q == WALK_R);
   assign aah        = (state_q == FALL_L) || (state_q == FALL_R);
   assign digging    = (state_q == DIG_L)  || (state_q == DIG_R);
   assign jumping    = (state_q == JUMP_L) || (state_q == JUMP_R);
   assign splat      = (state_q == SPLAT);

endmodule

// File: rtl/lemming_swarm_ctrl.sv
// N independent lemming channels plus a live-lemming popcount.
// Bit i of every vector belongs to channel i.
module lemming_swarm_ctrl
   import lemming_pkg::*;
#(
   parameter int N_LEM       = 4,
   parameter int FALL_LIMIT  = 20,
   parameter int JUMP_CYCLES = 3,
   parameter int DIG_LIMIT   = 0
) (
   input  logic                         clk,
   input  logic                         areset,
   input  logic [N_LEM-1:0]             ground,
   input  logic [N_LEM-1:0]             bump_left,
   input  logic [N_LEM-1:0]             bump_right,
   input  logic [N_LEM-1:0]             small_bump_left,
   input  logic [N_LEM-1:0]             small_bump_right,
   input  logic [N_LEM-1:0]             dig,
   input  logic [N_LEM-1:0]             revive,
   output logic [N_LEM-1:0]             walk_left,
   output logic [N_LEM-1:0]             walk_right,
   output logic [N_LEM-1:0]             aah,
   output logic [N_LEM-1:0]             digging,
   output logic [N_LEM-1:0]             jumping,
   output logic [N_LEM-1:0]             splat,
   output logic [$clog2(N_LEM+1)-1:0]   alive_count
);

   localparam int AW = $clog2(N_LEM + 1);

   for (genvar i = 0; i < N_LEM; i++) begin : g_lem
      lemming_core #(
         .FALL_LIMIT  (FALL_LIMIT),
         .JUMP_CYCLES (JUMP_CYCLES),
         .DIG_LIMIT   (DIG_LIMIT)
      ) u_core (
         .clk              (clk),
         .areset           (areset),
         .ground           (ground[i]),
         .bump_left        (bump_left[i]),
         .bump_right       (bump_right[i]),
         .small_bump_left  (small_bump_left[i]),
         .small_bump_right (small_bump_right[i]),
         .dig              (dig[i]),
         .revive           (revive[i]),
         .walk_left        (walk_left[i]),
         .walk_right       (walk_right[i]),
         .aah              (aah[i]),
         .digging          (digging[i]),
         .jumping          (jumping[i]),
         .splat            (splat[i])
      );
   end

   always_comb begin
      alive_count = '0;
      for (int i = 0; i < N_LEM; i++) begin
         alive_count = alive_count + AW'(!splat[i]);
      end
   end

endmodule

// File: tb/tb_lemming_swarm_ctrl.sv
// Self-checking bench for lemming_swarm_ctrl: directed scenarios then
// random terrain, compared against an activity/elapsed-time model.
module tb_lemming_swarm_ctrl;

   localparam int N  = 4;
   localparam int FL = 4;
   localparam int JC = 3;
   localparam int DL = 5;

   localparam int A_WALK = 0;
   localparam int A_FALL = 1;
   localparam int A_DIG  = 2;
   localparam int A_JUMP = 3;
   localparam int A_DEAD = 4;

   logic         clk = 1'b0;
   logic         areset = 1'b1;
   logic [N-1:0] ground = '1;
   logic [N-1:0] bump_left = '0;
   logic [N-1:0] bump_right = '0;
   logic [N-1:0] small_bump_left = '0;
   logic [N-1:0] small_bump_right = '0;
   logic [N-1:0] dig = '0;
   logic [N-1:0] revive = '0;
   logic [N-1:0] walk_left, walk_right, aah, digging, jumping, splat;
   logic [2:0]   alive_count;

   int act [N];
   int dir [N];
   int el  [N];
   int n_vec = 0;
   int n_err = 0;

   lemming_swarm_ctrl #(
      .N_LEM       (N),
      .FALL_LIMIT  (FL),
      .JUMP_CYCLES (JC),
      .DIG_LIMIT   (DL)
   ) dut (
      .clk              (clk),
      .areset           (areset),
      .ground           (ground),
      .bump_left        (bump_left),
      .bump_right       (bump_right),
      .small_bump_left  (small_bump_left),
      .small_bump_right (small_bump_right),
      .dig              (dig),
      .revive           (revive),
      .walk_left        (walk_left),
      .walk_right       (walk_right),
      .aah              (aah),
      .digging          (digging),
      .jumping          (jumping),
      .splat            (splat),
      .alive_count      (alive_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp,
                  $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         act[i] = A_WALK;
         dir[i] = 0;
         el[i]  = 0;
      end
   endfunction

   function automatic void model_step();
      for (int i = 0; i < N; i++) begin
         case (act[i])
            A_DEAD: begin
               if (revive[i]) begin
                  act[i] = A_WALK;
                  dir[i] = 0;
               end
            end
            A_WALK: begin
               el[i] = 0;
               if (!ground[i]) act[i] = A_FALL;
               else if (dig[i]) act[i] = A_DIG;
               else if (dir[i] == 0 ? bump_left[i] : bump_right[i])
                  dir[i] = 1 - dir[i];
               else if (dir[i] == 0 ? small_bump_left[i] : small_bump_right[i])
                  act[i] = A_JUMP;
            end
            A_FALL: begin
               el[i]++;
               if (ground[i]) act[i] = (el[i] >= FL) ? A_DEAD : A_WALK;
            end
            A_DIG: begin
               el[i]++;
               if (!ground[i]) begin
                  act[i] = A_FALL;
                  el[i]  = 0;
               end else if (DL > 0 && el[i] == DL) act[i] = A_WALK;
            end
            default: begin
               el[i]++;
               if (!ground[i]) begin
                  act[i] = A_FALL;
                  el[i]  = 0;
               end else if (el[i] == JC) act[i] = A_WALK;
            end
         endcase
      end
   endfunction

   task automatic check_all(input string tag);
      logic [N-1:0] e_wl, e_wr, e_aah, e_dig, e_jmp, e_spl;
      int alive;
      alive = 0;
      for (int i = 0; i < N; i++) begin
         e_wl[i]  = (act[i] == A_WALK) && (dir[i] == 0);
         e_wr[i]  = (act[i] == A_WALK) && (dir[i] == 1);
         e_aah[i] = (act[i] == A_FALL);
         e_dig[i] = (act[i] == A_DIG);
         e_jmp[i] = (act[i] == A_JUMP);
         e_spl[i] = (act[i] == A_DEAD);
         if (act[i] != A_DEAD) alive++;
      end
      chk({tag, ".walk_left"},   32'(walk_left),   32'(e_wl));
      chk({tag, ".walk_right"},  32'(walk_right),  32'(e_wr));
      chk({tag, ".aah"},         32'(aah),         32'(e_aah));
      chk({tag, ".digging"},     32'(digging),     32'(e_dig));
      chk({tag, ".jumping"},     32'(jumping),     32'(e_jmp));
      chk({tag, ".splat"},       32'(splat),       32'(e_spl));
      chk({tag, ".alive_count"}, 32'(alive_count), 32'(alive));
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   task automatic run(input logic [N-1:0] g, input logic [N-1:0] bl,
                      input logic [N-1:0] br, input logic [N-1:0] sbl,
                      input logic [N-1:0] sbr, input logic [N-1:0] dg,
                      input logic [N-1:0] rv, input int n,
                      input string tag);
      ground           = g;
      bump_left        = bl;
      bump_right       = br;
      small_bump_left  = sbl;
      small_bump_right = sbr;
      dig              = dg;
      revive           = rv;
      repeat (n) cycle(tag);
   endtask

   // Async reset pulse placed between clock edges.
   task automatic hit_reset(input string tag);
      cycle({tag, ".pre"});
      #2 areset = 1'b1;
      #1 model_reset();
      check_all({tag, ".async"});
      chk({tag, ".wl_ff"}, 32'(walk_left), 32'hF);
      #2 areset = 1'b0;
   endtask

   function automatic logic [N-1:0] rbits(input int pct);
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 99) < pct);
      return v;
   endfunction

   initial begin
      logic [N-1:0] r;
      model_reset();
      #3;
      check_all("reset");
      chk("reset.alive", 32'(alive_count), 32'd4);
      #4 areset = 1'b0;

      run('1, '0, '0, '0, '0, '0, '0, 2, "s1.idle");
      run('1, 4'h1, '0, '0, '0, '0, '0, 1, "s1.bump");
      chk("s1.ch0_right", 32'(walk_right[0]), 32'd1);
      run('1, '0, '0, '0, '0, '0, '0, 2, "s1.idle2");

      run(4'hD, '0, '0, '0, '0, '0, '0, 3, "s2.fall3");
      chk("s2.aah1", 32'(aah[1]), 32'd1);
      run('1, '0, '0, '0, '0, '0, '0, 1, "s2.land");
      chk("s2.walk1", 32'(walk_left[1]), 32'd1);
      run(4'hD, '0, '0, '0, '0, '0, '0, 4, "s2.fall4");
      run('1, '0, '0, '0, '0, '0, '0, 1, "s2.splat");
      chk("s2.splat1", 32'(splat[1]), 32'd1);
      chk("s2.alive3", 32'(alive_count), 32'd3);

      run('1, '0, '0, 4'h4, '0, '0, '0, 1, "s3.jump");
      chk("s3.jump2", 32'(jumping[2]), 32'd1);
      run('1, '0, '0, 4'h4, '0, '0, '0, 7, "s3.hold");
      run(4'hB, '0, '0, 4'h4, '0, '0, '0, 2, "s3.drop");
      run('1, '0, '0, '0, '0, '0, '0, 3, "s3.rec");

      run('1, '0, '0, '0, '0, 4'h8, '0, 1, "s4.dig");
      chk("s4.dig3", 32'(digging[3]), 32'd1);
      run('1, '0, '0, '0, '0, '0, '0, 5, "s4.dighold");
      chk("s4.done3", 32'(walk_left[3]), 32'd1);
      run('1, '0, '0, '0, '0, 4'h8, '0, 1, "s4.dig2");
      run('1, '0, '0, '0, '0, '0, '0, 1, "s4.dig2b");
      run(4'h7, '0, '0, '0, '0, '0, '0, 1, "s4.drop");
      chk("s4.aah3", 32'(aah[3]), 32'd1);
      run('1, '0, '0, '0, '0, '0, '0, 2, "s4.rec");

      for (int k = 0; k < 6; k++) begin
         r = N'($urandom);
         run(4'hD | (r & 4'h2), r & 4'h2, (r << 1) & 4'h2,
             (r >> 1) & 4'h2, r & 4'h2, (r >> 2) & 4'h2, '0, 1, "s5.tog");
      end
      chk("s5.still", 32'(splat[1]), 32'd1);
      run('1, '0, '0, '0, '0, '0, 4'h2, 1, "s5.revive");
      chk("s5.wl1", 32'(walk_left[1]), 32'd1);
      chk("s5.alive4", 32'(alive_count), 32'd4);

      run('1, '0, '0, 4'hF, 4'hF, '0, '0, 1, "s6.jump");
      ground = '1;
      hit_reset("s6.rj");
      run('0, '0, '0, '0, '0, '0, '0, 2, "s6.fall");
      ground = '0;
      hit_reset("s6.rf");
      chk("s6.alive", 32'(alive_count), 32'd4);

      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 59) == 0) begin
            hit_reset("rnd");
         end else begin
            run(rbits(85), rbits(10), rbits(10), rbits(12), rbits(12),
                rbits(5), rbits(15), 1, "rnd");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
